// File: rtl/display_scan_ctrl_if.sv
// Write port into the display digit buffer.
// The requester holds req, digit and value until it sees a one-cycle grant.
interface display_scan_ctrl_if;
   logic       req;
   logic [2:0] digit;
   logic [3:0] value;
   logic       grant;

   modport master (output req, output digit, output value, input grant);
   modport slave  (input req, input digit, input value, output grant);
endinterface

// File: rtl/display_scan_ctrl.sv
// Seven-segment scan scheduler: round-robin CPU/debug writes into an
// 8-digit buffer, one digit per slot with a blanking gap and PWM brightness.
module display_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int TICK_DIV     = 20000,
   parameter int BLANK_CYCLES = 16,
   parameter int PWM_BITS     = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_enable,
   input  logic [PWM_BITS-1:0]   i_brightness,
   display_scan_ctrl_if.slave    io_cpu,
   display_scan_ctrl_if.slave    io_dbg,
   output logic [3:0]            o_digit_bcd,
   output logic [NUM_DIGITS-1:0] o_digit_sel,
   output logic                  o_frame_done
);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SLOT_W = $clog2(TICK_DIV);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_e;
   typedef enum logic {PRI_CPU, PRI_DBG} pri_e;

   // ---------------- write arbiter ----------------
   logic                  w_cpu_elig;
   logic                  w_dbg_elig;
   logic                  w_pick_cpu;
   logic                  w_pick_dbg;
   logic                  w_wr_en;
   logic [2:0]            w_wr_digit;
   logic [3:0]            w_wr_value;
   logic                  r_cpu_grant;
   logic                  r_dbg_grant;
   pri_e                  r_pri;
   logic [3:0]            r_buf [NUM_DIGITS];

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      w_cpu_elig = io_cpu.req & ~r_cpu_grant;
      w_dbg_elig = io_dbg.req & ~r_dbg_grant;
      w_pick_cpu = w_cpu_elig & (~w_dbg_elig | (r_pri == PRI_CPU));
      w_pick_dbg = w_dbg_elig & ~w_pick_cpu;
      w_wr_en    = w_pick_cpu | w_pick_dbg;
      w_wr_digit = w_pick_cpu ? io_cpu.digit : io_dbg.digit;
      w_wr_value = w_pick_cpu ? io_cpu.value : io_dbg.value;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cpu_grant <= 1'b0;
         r_dbg_grant <= 1'b0;
         r_pri       <= PRI_CPU;
      end else begin
         r_cpu_grant <= w_pick_cpu;
         r_dbg_grant <= w_pick_dbg;
         if (w_pick_cpu) begin
            r_pri <= PRI_DBG;
         end else if (w_pick_dbg) begin
            r_pri <= PRI_CPU;
         end
      end
   end

   assign io_cpu.grant = r_cpu_grant;
   assign io_dbg.grant = r_dbg_grant;

   // NOTE: the buffer is only a few flops and must read as zero after reset, so it is reset explicitly.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_buf[i] <= 4'h0;
         end
      end else if (w_wr_en) begin
         // Indices with no matching digit are granted but dropped here.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_wr_digit == 3'(i)) begin
               r_buf[i] <= w_wr_value;
            end
         end
      end
   end

   // ---------------- scan scheduler ----------------
   scan_state_e           r_state;
   scan_state_e           w_state_next;
   logic [SLOT_W-1:0]     r_slot_cnt;
   logic [SLOT_W-1:0]     w_slot_next;
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W-1:0]      w_idx_next;
   logic [PWM_BITS-1:0]   r_pwm_cnt;
   logic [PWM_BITS-1:0]   w_pwm_next;
   logic [PWM_BITS-1:0]   r_duty;
   logic                  w_slot_start;
   logic [NUM_DIGITS-1:0] w_sel_next;
   logic                  w_frame_done_next;
   logic [3:0]            r_digit_bcd;
   logic [NUM_DIGITS-1:0] r_digit_sel;
   logic                  r_frame_done;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_slot_next  = r_slot_cnt;
      w_idx_next   = r_idx;
      w_pwm_next   = r_pwm_cnt;
      w_slot_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_slot_next = '0;
            w_pwm_next  = '0;
            w_idx_next  = '0;
            if (i_enable) begin
               w_state_next = S_BLANK;
               w_slot_start = 1'b1;
            end
         end
         S_BLANK: begin
            w_slot_next = r_slot_cnt + 1'b1;
            w_pwm_next  = '0;
            if (r_slot_cnt == SLOT_W'(BLANK_CYCLES - 1)) begin
               w_state_next = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (r_slot_cnt == SLOT_W'(TICK_DIV - 1)) begin
               w_state_next = S_BLANK;
               w_slot_next  = '0;
               w_pwm_next   = '0;
               w_slot_start = 1'b1;
               w_idx_next   = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
               w_slot_next = r_slot_cnt + 1'b1;
               // PWM phase restarts each slot so every digit gets the same duty pattern.
               w_pwm_next  = r_pwm_cnt + 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      if (!i_enable) begin
         w_state_next = S_IDLE;
         w_slot_next  = '0;
         w_pwm_next   = '0;
         w_idx_next   = '0;
         w_slot_start = 1'b0;
      end

      // Outputs are precomputed from next-state values so the panel pins come straight off flops.
      w_sel_next = '1;
      if ((w_state_next == S_DRIVE) && (w_pwm_next <= r_duty)) begin
         w_sel_next = ~(NUM_DIGITS'(1) << w_idx_next);
      end
      w_frame_done_next = (w_state_next == S_DRIVE)
                       && (w_slot_next == SLOT_W'(TICK_DIV - 1))
                       && (w_idx_next == IDX_W'(NUM_DIGITS - 1));
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_slot_cnt   <= '0;
         r_idx        <= '0;
         r_pwm_cnt    <= '0;
         r_duty       <= '0;
         r_digit_bcd  <= 4'h0;
         r_digit_sel  <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_slot_cnt   <= w_slot_next;
         r_idx        <= w_idx_next;
         r_pwm_cnt    <= w_pwm_next;
         r_digit_sel  <= w_sel_next;
         r_frame_done <= w_frame_done_next;
         // Snapshot at slot start: writes landing mid-slot appear on the next scan.
         if (w_slot_start) begin
            r_digit_bcd <= r_buf[w_idx_next];
            r_duty      <= i_brightness;
         end
      end
   end

   assign o_digit_bcd  = r_digit_bcd;
   assign o_digit_sel  = r_digit_sel;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random
// write/brightness/enable traffic checked cycle by cycle against a slot-time model.
module tb_display_scan_ctrl;
   localparam int NUM_DIGITS   = 8;
   localparam int TICK_DIV     = 40;
   localparam int BLANK_CYCLES = 4;
   localparam int PWM_BITS     = 4;
   localparam int FRAME        = NUM_DIGITS * TICK_DIV;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  enable;
   logic [PWM_BITS-1:0]   brightness;
   logic [3:0]            digit_bcd;
   logic [NUM_DIGITS-1:0] digit_sel;
   logic                  frame_done;

   display_scan_ctrl_if cpu_if ();
   display_scan_ctrl_if dbg_if ();

   display_scan_ctrl #(
      .NUM_DIGITS  (NUM_DIGITS),
      .TICK_DIV    (TICK_DIV),
      .BLANK_CYCLES(BLANK_CYCLES),
      .PWM_BITS    (PWM_BITS)
   ) dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_enable    (enable),
      .i_brightness(brightness),
      .io_cpu      (cpu_if),
      .io_dbg      (dbg_if),
      .o_digit_bcd (digit_bcd),
      .o_digit_sel (digit_sel),
      .o_frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: scan position is simply cycles since scanning began.
   logic [3:0]          m_buf [NUM_DIGITS];
   bit                  m_run;
   int                  m_t;
   logic [3:0]          m_bcd;
   logic [PWM_BITS-1:0] m_duty;
   bit                  m_cpu_g;
   bit                  m_dbg_g;
   bit                  m_cpu_last;
   int                  fd_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_buf[i]) m_buf[i] = 4'h0;
      m_run      = 1'b0;
      m_t        = 0;
      m_bcd      = 4'h0;
      m_duty     = '0;
      m_cpu_g    = 1'b0;
      m_dbg_g    = 1'b0;
      m_cpu_last = 1'b0;
   endtask

   function automatic logic [NUM_DIGITS-1:0] exp_sel();
      logic [NUM_DIGITS-1:0] one = 1;
      int slot;
      int pos;
      if (!m_run) return '1;
      slot = (m_t / TICK_DIV) % NUM_DIGITS;
      pos  = m_t % TICK_DIV;
      if (pos < BLANK_CYCLES) return '1;
      if (((pos - BLANK_CYCLES) % (1 << PWM_BITS)) <= int'(m_duty)) return ~(one << slot);
      return '1;
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      bit cpu_c, dbg_c, take_cpu, take_dbg;
      @(posedge clk);
      cpu_c    = cpu_if.req && !m_cpu_g;
      dbg_c    = dbg_if.req && !m_dbg_g;
      take_cpu = cpu_c && (!dbg_c || !m_cpu_last);
      take_dbg = dbg_c && !take_cpu;
      if (!enable) m_run = 1'b0;
      else if (!m_run) begin
         m_run = 1'b1;
         m_t   = 0;
      end else m_t++;
      if (m_run && (m_t % TICK_DIV) == 0) begin
         m_bcd  = m_buf[(m_t / TICK_DIV) % NUM_DIGITS];
         m_duty = brightness;
      end
      if (take_cpu) begin
         if (int'(cpu_if.digit) < NUM_DIGITS) m_buf[cpu_if.digit] = cpu_if.value;
         m_cpu_last = 1'b1;
      end
      if (take_dbg) begin
         if (int'(dbg_if.digit) < NUM_DIGITS) m_buf[dbg_if.digit] = dbg_if.value;
         m_cpu_last = 1'b0;
      end
      m_cpu_g = take_cpu;
      m_dbg_g = take_dbg;
      #1;
      check("digit_sel",  32'(digit_sel),  32'(exp_sel()));
      check("digit_bcd",  32'(digit_bcd),  32'(m_bcd));
      check("frame_done", 32'(frame_done), 32'(m_run && (m_t % FRAME) == FRAME - 1));
      check("cpu_grant",  32'(cpu_if.grant), 32'(m_cpu_g));
      check("dbg_grant",  32'(dbg_if.grant), 32'(m_dbg_g));
      fd_seen += int'(frame_done);
   endtask

   task automatic wait_sel(input logic [NUM_DIGITS-1:0] pat, input int budget, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         step();
         hit = (digit_sel == pat);
      end
   endtask

   // Count lit cycles over the first 32 DRIVE cycles of a slot at a given brightness.
   task automatic measure_duty(input logic [PWM_BITS-1:0] b, input int exp_low, input string tag);
      int low = 0;
      brightness = b;
      for (int i = 0; i < TICK_DIV + 1; i++) begin
         step();
         if (m_t % TICK_DIV == 0) break;
      end
      repeat (BLANK_CYCLES - 1) step();
      repeat (32) begin
         step();
         low += (digit_sel != '1) ? 1 : 0;
      end
      check(tag, 32'(low), 32'(exp_low));
   endtask

   task automatic drive_req_random();
      if (!cpu_if.req || m_cpu_g) begin
         cpu_if.req   = ($urandom_range(2) == 0);
         cpu_if.digit = 3'($urandom_range(7));
         cpu_if.value = 4'($urandom_range(15));
      end
      if (!dbg_if.req || m_dbg_g) begin
         dbg_if.req   = ($urandom_range(2) == 0);
         dbg_if.digit = 3'($urandom_range(7));
         dbg_if.value = 4'($urandom_range(15));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      rst_n        = 1'b0;
      enable       = 1'b0;
      brightness   = '0;
      cpu_if.req   = 1'b0;
      cpu_if.digit = 3'd0;
      cpu_if.value = 4'h0;
      dbg_if.req   = 1'b0;
      dbg_if.digit = 3'd0;
      dbg_if.value = 4'h0;
      model_reset();
      fd_seen = 0;

      #12;
      check("rst_sel",   32'(digit_sel),    32'hFF);
      check("rst_bcd",   32'(digit_bcd),    32'h0);
      check("rst_fd",    32'(frame_done),   32'h0);
      check("rst_cgnt",  32'(cpu_if.grant), 32'h0);
      check("rst_dgnt",  32'(dbg_if.grant), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // Scan start at full brightness, with both requesters competing for digit 1.
      brightness   = 4'hF;
      enable       = 1'b1;
      cpu_if.req   = 1'b1; cpu_if.digit = 3'd1; cpu_if.value = 4'h1;
      dbg_if.req   = 1'b1; dbg_if.digit = 3'd1; dbg_if.value = 4'h2;
      for (int i = 0; i < 6; i++) begin
         step();
         check("rr_cpu", 32'(cpu_if.grant), 32'(i % 2 == 0));
         check("rr_dbg", 32'(dbg_if.grant), 32'(i % 2 == 1));
      end
      cpu_if.req = 1'b0;
      dbg_if.req = 1'b0;
      repeat (2 * FRAME + 5 - 6) begin
         step();
         if (digit_sel == 8'hFD) check("rr_last_write", 32'(digit_bcd), 32'h2);
      end
      check("frame_count", 32'(fd_seen), 32'd2);

      // Single CPU write held one cycle past its grant.
      cpu_if.req = 1'b1; cpu_if.digit = 3'd3; cpu_if.value = 4'hA;
      step();
      check("cpu_grant_pulse", 32'(cpu_if.grant), 32'h1);
      step();
      check("cpu_grant_once", 32'(cpu_if.grant), 32'h0);
      cpu_if.req = 1'b0;
      wait_sel(8'hF7, FRAME + TICK_DIV, ok);
      check("slot3_reached", 32'(ok), 32'h1);
      check("slot3_bcd", 32'(digit_bcd), 32'hA);

      measure_duty(4'd3, 8, "duty_b3");
      measure_duty(4'd0, 2, "duty_b0");
      measure_duty(4'd15, 32, "duty_b15");

      // Write digit 2 during its own DRIVE phase: display holds until its next slot.
      for (int i = 0; i < FRAME + 1; i++) begin
         step();
         if ((m_t / TICK_DIV) % NUM_DIGITS == 2 && m_t % TICK_DIV == BLANK_CYCLES + 2) break;
      end
      dbg_if.req = 1'b1; dbg_if.digit = 3'd2; dbg_if.value = 4'h7;
      step();
      check("mid_slot_grant", 32'(dbg_if.grant), 32'h1);
      dbg_if.req = 1'b0;
      repeat (TICK_DIV - BLANK_CYCLES - 4) begin
         step();
         check("mid_slot_hold", 32'(digit_bcd), 32'h0);
      end
      wait_sel(8'hFB, FRAME + TICK_DIV, ok);
      check("slot2_reached", 32'(ok), 32'h1);
      check("slot2_bcd", 32'(digit_bcd), 32'h7);

      // Random traffic.
      for (int c = 0; c < 4000; c++) begin
         drive_req_random();
         if ($urandom_range(63) == 0) brightness = 4'($urandom_range(15));
         if (enable) enable = ($urandom_range(499) != 0);
         else        enable = ($urandom_range(19) == 0);
         step();
      end
      cpu_if.req = 1'b0;
      dbg_if.req = 1'b0;

      // Enable drop at cycle 100, then reset during a grant.
      enable = 1'b0;
      step();
      enable = 1'b1;
      repeat (100) step();
      enable = 1'b0;
      repeat (3) begin
         step();
         check("dark_sel", 32'(digit_sel), 32'hFF);
      end
      cpu_if.req = 1'b1; cpu_if.digit = 3'd0; cpu_if.value = 4'h9;
      step();
      check("pre_rst_grant", 32'(cpu_if.grant), 32'h1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_sel",   32'(digit_sel),    32'hFF);
      check("mid_rst_grant", 32'(cpu_if.grant), 32'h0);
      check("mid_rst_bcd",   32'(digit_bcd),    32'h0);
      cpu_if.req = 1'b0;
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      enable     = 1'b1;
      brightness = 4'hF;
      wait_sel(8'hFE, 10, ok);
      check("restart_digit0", 32'(ok), 32'h1);
      check("restart_bcd", 32'(digit_bcd), 32'h0);
      repeat (FRAME) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Scan scheduler and write arbiter for the 8-digit seven-segment display. It holds a digit buffer written by two requesters, a CPU port and a debug port, which share it under round-robin arbitration. It time-multiplexes one digit at a time onto the panel, with a blanking gap between digits and per-frame brightness PWM. The digit_bcd output feeds the bcd_to_hex segment decoder; digit_sel drives the active-low digit enables on the board.

Parameters:
NUM_DIGITS, 8, number of digits scanned; fixes the width of digit_sel and the digit index (3 bits at default).
TICK_DIV, 20000, clock cycles per digit slot (100 MHz gives a 5 kHz slot rate); minimum BLANK_CYCLES+16.
BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (anti-ghosting).
PWM_BITS, 4, width of the brightness input and of the PWM phase counter.

Ports:
clock  in  1  system clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  1 = scanning; 0 = panel dark
brightness  in  PWM_BITS  duty control; sampled at each slot start
cpu_req  in  1  CPU write request; held until granted
cpu_digit  in  3  CPU target digit index
cpu_value  in  4  CPU BCD/hex nibble
cpu_grant  out  1  one-cycle pulse; CPU write accepted
dbg_req  in  1  debug write request; held until granted
dbg_digit  in  3  debug target digit index
dbg_value  in  4  debug nibble
dbg_grant  out  1  one-cycle pulse; debug write accepted
digit_bcd  out  4  nibble of the digit currently scanned
digit_sel  out  NUM_DIGITS  active-low one-cold digit enable
frame_done  out  1  one-cycle pulse at the end of the last digit's slot

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Outputs: digit_sel=all ones, digit_bcd=0, cpu_grant=0, dbg_grant=0, frame_done=0.
  - Internal: buffer all zeros, digit index=0, slot counter=0, PWM counter=0, round-robin pointer=CPU-first, state=IDLE.
- Arbitration (independent of scan state; one write per cycle):
  - A grant is registered. It asserts on the edge after a request is seen, provided no grant was given the previous cycle to that requester.
  - The buffer entry is written on the same edge the grant asserts.
  - Simultaneous requests: the grant goes to the requester not granted last. The pointer then flips to the other requester.
  - A sole requester is always granted.
  - A requester still asserting req after its grant pulse is treated as a new request. This allows at most one grant every 2 cycles per requester when both requesters compete.
  - Digit index values >= NUM_DIGITS are granted but not written.
- Scan state machine:
  - IDLE:
    - digit_sel=all ones; counters held at 0.
    - enable=1 -> BLANK on the next edge, with digit index=0.
  - BLANK (BLANK_CYCLES cycles):
    - digit_sel=all ones.
    - On entry, latch buffer[index] into digit_bcd and brightness into the duty register. This gives tear-free display; writes during a slot show next scan.
    - -> DRIVE.
  - DRIVE (TICK_DIV-BLANK_CYCLES cycles):
    - The PWM counter free-runs once per cycle and wraps at 2^PWM_BITS.
    - digit_sel bit[index]=0 when pwm_cnt <= duty, else all ones.
    - duty=0 gives 1/16 duty; duty=15 gives always on.
    - At slot end: index increments, wrapping NUM_DIGITS-1 -> 0, then -> BLANK.
- Slot counter: counts 0..TICK_DIV-1 and resets at every BLANK entry.
- frame_done: pulses during the cycle in which the slot of index NUM_DIGITS-1 ends.
- Outputs digit_sel, digit_bcd and frame_done are registered: no combinational path from inputs.
- enable falling mid-slot: at the next edge go to IDLE; digit_sel=all ones; no frame_done. A later re-enable restarts at digit 0.
- Writes are accepted in every state, including IDLE.
- Reset asserted mid-write: the grant and the write are lost.

Test Plan:
Use TICK_DIV=40 and BLANK_CYCLES=4 in all scenarios.
1. Reset then enable=1, brightness=15, buffer all 0 -> digit_sel patterns 8'hFE, 8'hFD, ... 8'h7F. Each pattern is low for 36 cycles after 4 cycles of 8'hFF. frame_done pulses every 320 cycles.
2. cpu_req with digit 3, value 0xA, held 1 cycle past its grant -> cpu_grant pulses once, one cycle after the request. digit_bcd=0xA during digit 3's slot (digit_sel=8'hF7) on the next scan.
3. cpu_req and dbg_req held together for 6 cycles -> grants alternate CPU, DBG, CPU, ...; the write order is preserved in the buffer.
4. brightness=3 -> in DRIVE, digit_sel is low for 4 of every 16 cycles. brightness=0 -> low for 1 of every 16 cycles.
5. Write digit 2 during digit 2's DRIVE phase -> digit_bcd is unchanged until the next BLANK entry of digit 2.
6. enable dropped at cycle 100, then reset_n pulsed low mid-grant -> digit_sel=8'hFF immediately; grant is 0; after release, scan restarts at digit 0 with a zeroed buffer.
